// File: rtl/dff_pr_ureg.sv
// General-purpose WIDTH-bit state/shift/count register with synchronous clear/preset,
// clock enable, eight operating modes, registered carry/shift-out and a zero flag.
module dff_pr_ureg #(
  parameter int unsigned           WIDTH      = 8,
  parameter logic [WIDTH-1:0]      PRESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             co,
  output logic             zero
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHL  = 3'b010,
    M_SHR  = 3'b011,
    M_ROL  = 3'b100,
    M_ROR  = 3'b101,
    M_INC  = 3'b110,
    M_DEC  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] r_q;
  logic             r_co;
  logic [WIDTH-1:0] w_q_next;
  logic             w_co_next;
  mode_e            w_mode;

  assign w_mode = mode_e'(mode);

  // Every mode encoding is decoded explicitly so unused inputs never leak X into state.
  always_comb begin
    w_q_next  = r_q;
    w_co_next = r_co;
    case (w_mode)
      M_HOLD: begin
        w_q_next  = r_q;
        w_co_next = r_co;
      end
      M_LOAD: begin
        w_q_next  = d;
        w_co_next = 1'b0;
      end
      M_SHL: begin
        w_q_next  = {r_q[WIDTH-2:0], sin};
        w_co_next = r_q[WIDTH-1];
      end
      M_SHR: begin
        w_q_next  = {sin, r_q[WIDTH-1:1]};
        w_co_next = r_q[0];
      end
      M_ROL: begin
        w_q_next  = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_co_next = r_q[WIDTH-1];
      end
      M_ROR: begin
        w_q_next  = {r_q[0], r_q[WIDTH-1:1]};
        w_co_next = r_q[0];
      end
      M_INC: begin
        w_q_next  = r_q + 1'b1;
        w_co_next = (r_q == '1);
      end
      M_DEC: begin
        w_q_next  = r_q - 1'b1;
        w_co_next = (r_q == '0);
      end
      default: begin
        w_q_next  = r_q;
        w_co_next = r_co;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q  <= '0;
      r_co <= 1'b0;
    end else if (pr) begin
      r_q  <= PRESET_VAL;
      r_co <= 1'b0;
    end else if (en) begin
      r_q  <= w_q_next;
      r_co <= w_co_next;
    end
  end

  assign q    = r_q;
  assign qb   = ~r_q;
  assign co   = r_co;
  assign zero = (r_q == '0);

endmodule

// File: tb/tb_dff_pr_ureg.sv
// Scoreboard bench for dff_pr_ureg: an 8-bit default instance and a 4-bit instance
// with PRESET_VAL=4'h5, driven by directed vectors with hand-computed expectations.
module tb_dff_pr_ureg;

  typedef struct {
    logic [7:0] q;
    logic       co;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       rst8 = 1'b0, pr8 = 1'b0, en8 = 1'b0, sin8 = 1'b0;
  logic [2:0] mode8 = 3'b000;
  logic [7:0] d8 = 8'h00;
  logic [7:0] q8, qb8;
  logic       co8, zero8;

  // 4-bit instance
  logic       rst4 = 1'b0, pr4 = 1'b0, en4 = 1'b0, sin4 = 1'b0;
  logic [2:0] mode4 = 3'b000;
  logic [3:0] d4 = 4'h0;
  logic [3:0] q4, qb4;
  logic       co4, zero4;

  dff_pr_ureg u_dut8 (
    .clk(clk), .rst(rst8), .pr(pr8), .en(en8), .mode(mode8), .d(d8), .sin(sin8),
    .q(q8), .qb(qb8), .co(co8), .zero(zero8)
  );

  dff_pr_ureg #(.WIDTH(4), .PRESET_VAL(4'h5)) u_dut4 (
    .clk(clk), .rst(rst4), .pr(pr4), .en(en4), .mode(mode4), .d(d4), .sin(sin4),
    .q(q4), .qb(qb4), .co(co4), .zero(zero4)
  );

  exp_t sb8[$];
  exp_t sb4[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Inputs change on the falling edge; the expectation is what the next rising edge produces.
  task automatic v8(input logic r, input logic p, input logic e, input logic [2:0] m,
                    input logic [7:0] dd, input logic s,
                    input logic [7:0] eq, input logic ec, input string nm);
    exp_t x;
    @(negedge clk);
    rst8 = r; pr8 = p; en8 = e; mode8 = m; d8 = dd; sin8 = s;
    x.q = eq; x.co = ec; x.name = nm;
    sb8.push_back(x);
  endtask

  task automatic v4(input logic r, input logic p, input logic e, input logic [2:0] m,
                    input logic [3:0] dd, input logic s,
                    input logic [3:0] eq, input logic ec, input string nm);
    exp_t x;
    @(negedge clk);
    rst4 = r; pr4 = p; en4 = e; mode4 = m; d4 = dd; sin4 = s;
    x.q = {4'h0, eq}; x.co = ec; x.name = nm;
    sb4.push_back(x);
  endtask

  exp_t m8;
  always @(posedge clk) begin
    #1;
    if (sb8.size() > 0) begin
      m8 = sb8.pop_front();
      n_vec++;
      if (q8 !== m8.q || co8 !== m8.co || qb8 !== ~m8.q || zero8 !== (m8.q == 8'h00)) begin
        n_err++;
        $display("FAIL w8 %s: got q=%h qb=%h co=%b zero=%b, want q=%h qb=%h co=%b zero=%b",
                 m8.name, q8, qb8, co8, zero8, m8.q, ~m8.q, m8.co, (m8.q == 8'h00));
      end
    end
  end

  exp_t m4;
  logic [3:0] m4q;
  always @(posedge clk) begin
    #1;
    if (sb4.size() > 0) begin
      m4 = sb4.pop_front();
      m4q = m4.q[3:0];
      n_vec++;
      if (q4 !== m4q || co4 !== m4.co || qb4 !== ~m4q || zero4 !== (m4q == 4'h0)) begin
        n_err++;
        $display("FAIL w4 %s: got q=%h qb=%h co=%b zero=%b, want q=%h qb=%h co=%b zero=%b",
                 m4.name, q4, qb4, co4, zero4, m4q, ~m4q, m4.co, (m4q == 4'h0));
      end
    end
  end

  initial begin
    //   rst  pr   en   mode    d      sin   exp_q  co    name
    v8(1'b1,1'b1,1'b1,3'b001,8'hA5,1'b0, 8'h00,1'b0,"rst_a");
    v8(1'b1,1'b1,1'b1,3'b001,8'hA5,1'b0, 8'h00,1'b0,"rst_b");
    v8(1'b0,1'b1,1'b0,3'b000,8'h00,1'b0, 8'hFF,1'b0,"preset");
    v8(1'b0,1'b0,1'b1,3'b001,8'h3C,1'b0, 8'h3C,1'b0,"load3C");
    v8(1'b0,1'b0,1'b0,3'b110,8'h00,1'b0, 8'h3C,1'b0,"en0_a");
    v8(1'b0,1'b0,1'b0,3'b110,8'h00,1'b0, 8'h3C,1'b0,"en0_b");
    v8(1'b0,1'b0,1'b0,3'b110,8'h00,1'b0, 8'h3C,1'b0,"en0_c");
    v8(1'b0,1'b0,1'b1,3'b001,8'h81,1'b1, 8'h81,1'b0,"load81");
    v8(1'b0,1'b0,1'b1,3'b010,8'hFF,1'b0, 8'h02,1'b1,"shl");
    v8(1'b0,1'b0,1'b1,3'b011,8'h00,1'b1, 8'h81,1'b0,"shr");
    v8(1'b0,1'b0,1'b1,3'b001,8'h81,1'b0, 8'h81,1'b0,"load81b");
    v8(1'b0,1'b0,1'b1,3'b100,8'h00,1'b1, 8'h03,1'b1,"rol_a");
    v8(1'b0,1'b0,1'b1,3'b100,8'h00,1'b1, 8'h06,1'b0,"rol_b");
    v8(1'b0,1'b0,1'b1,3'b101,8'hFF,1'b1, 8'h03,1'b0,"ror");
    v8(1'b0,1'b0,1'b1,3'b001,8'hFE,1'b0, 8'hFE,1'b0,"loadFE");
    v8(1'b0,1'b0,1'b1,3'b110,8'h00,1'b0, 8'hFF,1'b0,"inc_a");
    v8(1'b0,1'b0,1'b1,3'b110,8'h00,1'b0, 8'h00,1'b1,"inc_wrap");
    v8(1'b0,1'b0,1'b1,3'b110,8'h00,1'b0, 8'h01,1'b0,"inc_c");
    v8(1'b0,1'b0,1'b1,3'b111,8'h00,1'b0, 8'h00,1'b0,"dec_a");
    v8(1'b0,1'b0,1'b1,3'b111,8'h00,1'b0, 8'hFF,1'b1,"dec_wrap");
    v8(1'b0,1'b0,1'b1,3'b000,8'h55,1'b1, 8'hFF,1'b1,"hold_en1");
    v8(1'b0,1'b0,1'b1,3'b001,8'h10,1'b0, 8'h10,1'b0,"load10");
    v8(1'b0,1'b0,1'b1,3'b110,8'h00,1'b0, 8'h11,1'b0,"inc11");
    v8(1'b0,1'b1,1'b1,3'b110,8'h00,1'b0, 8'hFF,1'b0,"pr_midcount");
    v8(1'b1,1'b1,1'b1,3'b110,8'h00,1'b0, 8'h00,1'b0,"rst_and_pr");
    v8(1'b0,1'b0,1'b0,3'b000,8'h00,1'b0, 8'h00,1'b0,"idle8");

    v4(1'b1,1'b0,1'b0,3'b000,4'h0,1'b0, 4'h0,1'b0,"rst4");
    v4(1'b0,1'b1,1'b1,3'b111,4'h0,1'b0, 4'h5,1'b0,"preset4");
    v4(1'b0,1'b0,1'b1,3'b110,4'h0,1'b0, 4'h6,1'b0,"inc4_6");
    v4(1'b0,1'b0,1'b1,3'b001,4'hE,1'b0, 4'hE,1'b0,"load4E");
    v4(1'b0,1'b0,1'b1,3'b110,4'h0,1'b0, 4'hF,1'b0,"inc4_F");
    v4(1'b0,1'b0,1'b1,3'b110,4'h0,1'b0, 4'h0,1'b1,"inc4_wrap");
    v4(1'b0,1'b0,1'b1,3'b110,4'h0,1'b0, 4'h1,1'b0,"inc4_1");
    v4(1'b0,1'b0,1'b1,3'b111,4'h0,1'b0, 4'h0,1'b0,"dec4_0");
    v4(1'b0,1'b0,1'b1,3'b111,4'h0,1'b0, 4'hF,1'b1,"dec4_wrap");
    v4(1'b0,1'b0,1'b1,3'b010,4'h0,1'b1, 4'hF,1'b1,"shl4");
    v4(1'b0,1'b0,1'b1,3'b011,4'h0,1'b0, 4'h7,1'b1,"shr4");
    v4(1'b1,1'b1,1'b1,3'b110,4'h0,1'b0, 4'h0,1'b0,"rst_pr4");
    v4(1'b0,1'b0,1'b0,3'b000,4'h0,1'b0, 4'h0,1'b0,"idle4");

    for (int unsigned i = 0; i < 20 && (sb8.size() > 0 || sb4.size() > 0); i++)
      @(posedge clk);
    #2;
    if (sb8.size() > 0 || sb4.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d/%0d expectations left unchecked, want 0/0", sb8.size(), sb4.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
